// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Read-side consumer of a first-word-fall-through FIFO. It pops one entry at a
//   time and sends it as an asynchronous serial frame. The frame is a start bit,
//   then DATA_W data bits LSB-first, then an optional even-parity bit, then
//   STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks. All outputs are
//   registered.
//
// Ports
//   clk         in   FIFO read clock; the block's only clock
//   rst         in   synchronous reset, active-high
//   rdata       in   FIFO head entry, valid whenever empty=0
//   empty       in   FIFO empty flag
//   tx_en       in   allows new frames to start; the current frame always completes
//   rinc        out  one-cycle FIFO pop strobe, asserted in the first start-bit cycle
//   tx          out  serial line, idles high
//   busy        out  high whenever a frame is in progress
//   frame_done  out  one-cycle pulse in the last cycle of the last stop bit
module fifo_uart_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rdata,
    input  logic              empty,
    input  logic              tx_en,
    output logic              rinc,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(DATA_W + 2);

    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]      BAUD_PRE  = 16'(CLKS_PER_BIT - 2);
    localparam logic [15:0]      BAUD_ONE  = 16'd1;
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              rinc_q, rinc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic can_launch;
    logic bit_end;
    logic do_launch;

    assign can_launch = tx_en & ~empty;
    assign bit_end    = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rinc_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rinc_q  <= rinc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        rinc_d    = 1'b0;
        done_d    = 1'b0;
        do_launch = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (can_launch) do_launch = 1'b1;
            end

            S_START: begin
                if (bit_end) begin
                    // Present data bit 0 and pre-shift so shift_q[0] is always the next bit.
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PARITY_EN) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                // Registered pulse: raise it one cycle early so it lands on the final cycle.
                if (idx_q == STOP_LAST && baud_q == BAUD_PRE) done_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == STOP_LAST) begin
                        if (can_launch) begin
                            do_launch = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (do_launch) begin
            state_d = S_START;
            shift_d = rdata;
            par_d   = ^rdata;
            tx_d    = 1'b0;
            rinc_d  = 1'b1;
            baud_d  = '0;
            idx_d   = '0;
        end
    end

    always_comb busy_d = (state_d != S_IDLE);

    assign rinc       = rinc_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx. A queue models the FIFO. Every popped entry pushes its
//   expected frame data onto a scoreboard queue. A monitor captures each frame from
//   its rinc pulse and compares it cycle by cycle with a frame built from the framing
//   rules. A second instance uses the alternate configuration (no parity, two stop
//   bits, two clocks per bit).
module tb_fifo_uart_tx;

    localparam int DW  = 4;
    localparam int CPB = 4;
    localparam int FA  = (1 + DW + 1 + 1) * CPB;    // 28
    localparam int CPB2 = 2;
    localparam int FB  = (1 + DW + 0 + 2) * CPB2;   // 14

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] rdata;
    logic       empty, tx_en;
    logic       rinc, tx, busy, frame_done;

    logic [3:0] rdata2;
    logic       empty2, tx_en2;
    logic       rinc2, tx2, busy2, frame_done2;

    fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .rdata(rdata), .empty(empty), .tx_en(tx_en),
        .rinc(rinc), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB2), .PARITY_EN(1'b0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .rdata(rdata2), .empty(empty2), .tx_en(tx_en2),
        .rinc(rinc2), .tx(tx2), .busy(busy2), .frame_done(frame_done2)
    );

    int checks = 0;
    int fails  = 0;

    logic [3:0] fifo_m[$];
    logic [3:0] exp_q[$];
    int  pops = 0, frames = 0, mon_done = 0, aborts = 0;
    int  idle_err = 0, idle_run = 0, last_gap = -1;
    bit  mon_en = 1'b0;
    bit  pend_pop = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Serial bit k of a frame: 0 start, 1..DW data LSB-first, optional even parity, then stop.
    function automatic logic frame_bit(input logic [3:0] d, input int k, input int par_en);
        if (k == 0) return 1'b0;
        if (k <= DW) return d[k-1];
        if (par_en != 0 && k == DW + 1) return (($countones(d) % 2) == 1);
        return 1'b1;
    endfunction

    task automatic refresh();
        empty = (fifo_m.size() == 0);
        rdata = empty ? 4'h0 : fifo_m[0];
    endtask

    task automatic push(input logic [3:0] v);
        fifo_m.push_back(v);
        refresh();
    endtask

    // Advance one clock; inputs change 1 time unit after the edge. A rinc seen at the
    // previous point pops the FIFO at this edge.
    task automatic tick();
        logic [3:0] e;
        @(posedge clk);
        #1;
        if (pend_pop) begin
            if (fifo_m.size() > 0) begin
                e = fifo_m.pop_front();
                exp_q.push_back(e);
                pops++;
            end else begin
                check("pop_while_empty", 1, 0);
            end
        end
        pend_pop = rinc;
        refresh();
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (mon_done < n && k < budget) begin
            tick();
            k++;
        end
        check("frame_wait_timeout", (mon_done >= n) ? 1 : 0, 1);
    endtask

    // Monitor: idle checks outside frames, full-frame capture from each rinc pulse.
    initial begin : monitor
        logic       txs[FA];
        logic [3:0] d;
        int  bad_tx, bad_done, bad_busy, bad_rinc;
        bit  aborted;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rinc && !rst) begin
                    last_gap = idle_run;
                    idle_run = 0;
                    frames++;
                    aborted  = 1'b0;
                    bad_done = 0; bad_busy = 0; bad_rinc = 0; bad_tx = 0;
                    for (int c = 0; c < FA; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        txs[c] = tx;
                        if (frame_done !== (c == FA - 1)) bad_done++;
                        if (busy !== 1'b1) bad_busy++;
                        if (rinc !== (c == 0)) bad_rinc++;
                    end
                    if (aborted) begin
                        aborts++;
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end else if (exp_q.size() == 0) begin
                        check("frame_without_pop", 0, 1);
                    end else begin
                        d = exp_q.pop_front();
                        for (int c = 0; c < FA; c++)
                            if (txs[c] !== frame_bit(d, c / CPB, 1)) bad_tx++;
                        check($sformatf("frame_tx_bad_cycles[%h]", d), bad_tx, 0);
                        check($sformatf("frame_done_pos[%h]", d), bad_done, 0);
                        check($sformatf("frame_busy[%h]", d), bad_busy, 0);
                        check($sformatf("frame_rinc_once[%h]", d), bad_rinc, 0);
                        mon_done++;
                    end
                end else begin
                    idle_run++;
                    if (!rst && (tx !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0 || rinc !== 1'b0))
                        idle_err++;
                end
            end
        end
    end

    initial begin : main
        int f0, n, k, bad2, done_bad2;
        rst    = 1'b1;
        tx_en  = 1'b1;
        rdata2 = 4'hF;
        empty2 = 1'b1;
        tx_en2 = 1'b1;
        push(4'hA);

        // 1: reset held with a non-empty FIFO
        for (int i = 0; i < 3; i++) begin
            tick();
            mon_en = 1'b1;
            check("reset_outputs{tx,rinc,busy,done}", {28'd0, tx, rinc, busy, frame_done}, 4'b1000);
        end
        check("reset_no_pop", fifo_m.size(), 1);
        rst = 1'b0;

        // 2: single frame 0xA
        wait_done(1, 60);
        repeat (4) tick();
        check("single_pops", pops, 1);
        check("single_idle_err", idle_err, 0);

        // 3: back-to-back 0x3 then 0x7
        push(4'h3);
        push(4'h7);
        wait_done(3, 100);
        check("b2b_gap", last_gap, 0);
        check("b2b_pops", pops, 3);
        repeat (4) tick();

        // 4a: empty for 50 cycles
        f0 = frames;
        repeat (50) tick();
        check("empty_no_frame", frames - f0, 0);
        check("empty_idle_err", idle_err, 0);

        // 4b: tx_en dropped mid-frame
        push(4'h5);
        push(4'h9);
        f0 = frames;
        k  = 0;
        while (frames == f0 && k < 20) begin tick(); k++; end
        check("gate_frame_started", frames - f0, 1);
        repeat (10) tick();
        tx_en = 1'b0;
        repeat (40) tick();
        check("gate_one_frame", frames - f0, 1);
        check("gate_fifo_count", fifo_m.size(), 1);
        check("gate_idle_err", idle_err, 0);
        tx_en = 1'b1;
        wait_done(5, 60);
        check("gate_drained", fifo_m.size(), 0);

        // 5: reset in the DATA state
        repeat (3) tick();
        push(4'h6);
        f0 = frames;
        k  = 0;
        while (frames == f0 && k < 20) begin tick(); k++; end
        repeat (6) tick();
        push(4'hC);
        rst = 1'b1;
        tick();
        check("midreset_{tx,busy}", {30'd0, tx, busy}, 2'b10);
        rst = 1'b0;
        wait_done(6, 60);
        check("midreset_aborts", aborts, 1);

        // Randomized traffic with tx_en toggling
        for (int i = 0; i < 12; i++) begin
            push(4'($urandom_range(0, 15)));
            n = $urandom_range(0, 40);
            for (int j = 0; j < n; j++) begin
                tx_en = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        tx_en = 1'b1;
        k = 0;
        while ((fifo_m.size() != 0 || exp_q.size() != 0 || busy) && k < 2000) begin tick(); k++; end
        repeat (3) tick();
        check("rand_drain_timeout", (k < 2000) ? 1 : 0, 1);
        check("rand_pops_vs_frames", pops, mon_done + aborts);
        check("rand_idle_err", idle_err, 0);

        // 6: alternate configuration sending 0xF
        empty2 = 1'b0;
        k = 0;
        while (!rinc2 && k < 10) begin tick(); k++; end
        check("cfg2_launch", rinc2, 1);
        bad2 = 0;
        done_bad2 = 0;
        for (int c = 0; c < FB; c++) begin
            if (c > 0) tick();
            if (c == 1) empty2 = 1'b1;
            if (tx2 !== frame_bit(4'hF, c / CPB2, 0)) bad2++;
            if (frame_done2 !== (c == FB - 1)) done_bad2++;
            if (busy2 !== 1'b1) bad2++;
            if (rinc2 !== (c == 0)) bad2++;
        end
        check("cfg2_frame_bad_cycles", bad2, 0);
        check("cfg2_done_pos", done_bad2, 0);
        tick();
        check("cfg2_idle_{tx,busy,done}", {29'd0, tx2, busy2, frame_done2}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
